// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and alignment helper for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } lsu_state_e;

    // Alignment only; the illegal size code is rejected separately by the caller.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian byte-lane steering: load extraction/extension and store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rd_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane(s) out of the memory word and extend to 32 bits.
    always_comb begin
        byte_sel    = mem_rd_i[{addr_lo_i, 3'b000} +: 8];
        half_sel    = addr_lo_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        load_data_o = mem_rd_i;
        case (size_i)
            SZ_BYTE: load_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
            default: load_data_o = mem_rd_i;
        endcase
    end

    // Overlay the right-aligned store data onto the current memory word.
    always_comb begin
        store_data_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                store_data_o = mem_rd_i;
                store_data_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                store_data_o = mem_rd_i;
                store_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: store_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed, combinational-read memory.
//   state  | meaning
//   IDLE   | ready for a request; checks alignment/range at accept
//   ACCESS | single memory cycle: load capture or read-modify-write store
//   RESP   | response held until the consumer takes it
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    input  logic [31:0]       mem_rd
);

    localparam logic [ADDR_W-1:0] MEM_WORDS_A = ADDR_W'(MEM_WORDS);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_err;
    logic [31:0]       load_data;
    logic [31:0]       store_data;

    assign req_err = (req_size == SZ_ILLEGAL)
                   | lsu_misaligned(req_size, req_addr[1:0])
                   | ((req_addr >> 2) >= MEM_WORDS_A);

    lsu_lane_align u_lane_align (
        .mem_rd_i     (mem_rd),
        .wdata_i      (wdata_q),
        .addr_lo_i    (addr_q[1:0]),
        .size_i       (size_q),
        .signed_i     (signed_q),
        .load_data_o  (load_data),
        .store_data_o (store_data)
    );

    // Next-state, request/response capture and memory-port decode from the current state.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        signed_d  = signed_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = req_err;
                    state_d  = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_a   = addr_q >> 2;
                mem_we  = we_q;
                mem_wd  = we_q ? store_data : 32'h0;
                rdata_d = we_q ? 32'h0 : load_data;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request fields and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 256 x 32 memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:255];
    int          we_count = 0;
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(256), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    assign mem_rd = (mem_a < 32'd256) ? mem[mem_a[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[7:0]] <= mem_wd;
            we_count <= we_count + 1;
        end
    end

    // Present a request for one accept edge, then scramble the request inputs.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_size   = 2'b11;
        req_signed = ~sg;
        req_addr   = 32'hFFFF_FFFC;
        req_wdata  = 32'hDEAD_BEEF;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_mis++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_mis++; $display("FAIL reset_resp_rdata: got %h expected 00000000", resp_rdata); end
        n_cmp++; if (resp_err !== 1'b0) begin n_mis++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
        n_cmp++; if (mem_we !== 1'b0) begin n_mis++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        n_cmp++; if (mem_a !== 32'h0) begin n_mis++; $display("FAIL reset_mem_a: got %h expected 00000000", mem_a); end
    endtask

    task automatic test_word_store();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        logic [31:0] idxs  [3];
        int          wc;
        addrs = '{32'h10, 32'h14, 32'h3FC};
        datas = '{32'h8899AABB, 32'h0BADF00D, 32'h12345678};
        idxs  = '{32'd4, 32'd5, 32'd255};
        for (int i = 0; i < 3; i++) begin
            wc = we_count;
            issue(1'b1, SZ_WORD, 1'b0, addrs[i], datas[i]);
            n_cmp++; if (mem_a !== idxs[i]) begin n_mis++; $display("FAIL wst_mem_a[%0d]: got %h expected %h", i, mem_a, idxs[i]); end
            n_cmp++; if (mem_wd !== datas[i]) begin n_mis++; $display("FAIL wst_mem_wd[%0d]: got %h expected %h", i, mem_wd, datas[i]); end
            n_cmp++; if (mem_we !== 1'b1) begin n_mis++; $display("FAIL wst_mem_we[%0d]: got %b expected 1", i, mem_we); end
            n_cmp++; if (resp_valid !== 1'b0) begin n_mis++; $display("FAIL wst_early_valid[%0d]: got %b expected 0", i, resp_valid); end
            n_cmp++; if (req_ready !== 1'b0) begin n_mis++; $display("FAIL wst_req_ready[%0d]: got %b expected 0", i, req_ready); end
            @(posedge clk);
            #1;
            n_cmp++; if (resp_valid !== 1'b1) begin n_mis++; $display("FAIL wst_resp_valid[%0d]: got %b expected 1", i, resp_valid); end
            n_cmp++; if (resp_err !== 1'b0) begin n_mis++; $display("FAIL wst_resp_err[%0d]: got %b expected 0", i, resp_err); end
            n_cmp++; if (resp_rdata !== 32'h0) begin n_mis++; $display("FAIL wst_resp_rdata[%0d]: got %h expected 00000000", i, resp_rdata); end
            n_cmp++; if (mem_we !== 1'b0) begin n_mis++; $display("FAIL wst_we_drop[%0d]: got %b expected 0", i, mem_we); end
            n_cmp++; if (we_count !== wc + 1) begin n_mis++; $display("FAIL wst_we_cycles[%0d]: got %0d expected %0d", i, we_count - wc, 1); end
            n_cmp++; if (mem[idxs[i][7:0]] !== datas[i]) begin n_mis++; $display("FAIL wst_mem_word[%0d]: got %h expected %h", i, mem[idxs[i][7:0]], datas[i]); end
            finish_resp();
        end
    endtask

    task automatic test_loads();
        logic [31:0] addrs [8];
        logic [1:0]  sizes [8];
        logic        sgns  [8];
        logic [31:0] exps  [8];
        addrs = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10, 32'h13, 32'h10, 32'h10};
        sizes = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_WORD};
        sgns  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exps  = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899,
                  32'hFFFFFFBB, 32'hFFFFFF88, 32'hFFFFAABB, 32'h8899AABB};
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, sizes[i], sgns[i], addrs[i], 32'h0);
            n_cmp++; if (mem_a !== 32'd4) begin n_mis++; $display("FAIL ld_mem_a[%0d]: got %h expected 00000004", i, mem_a); end
            n_cmp++; if (mem_we !== 1'b0) begin n_mis++; $display("FAIL ld_mem_we[%0d]: got %b expected 0", i, mem_we); end
            @(posedge clk);
            #1;
            n_cmp++; if (resp_valid !== 1'b1) begin n_mis++; $display("FAIL ld_resp_valid[%0d]: got %b expected 1", i, resp_valid); end
            n_cmp++; if (resp_rdata !== exps[i]) begin n_mis++; $display("FAIL ld_rdata[%0d]: got %h expected %h", i, resp_rdata, exps[i]); end
            n_cmp++; if (resp_err !== 1'b0) begin n_mis++; $display("FAIL ld_err[%0d]: got %b expected 0", i, resp_err); end
            finish_resp();
        end
    endtask

    task automatic test_subword_store();
        logic [31:0] st_addr [2];
        logic [1:0]  st_size [2];
        logic [31:0] st_data [2];
        logic [31:0] merged  [2];
        st_addr = '{32'h12, 32'h13};
        st_size = '{SZ_HALF, SZ_BYTE};
        st_data = '{32'hDEAD1234, 32'hFFFFFF77};
        merged  = '{32'h1234AABB, 32'h7734AABB};
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, st_size[i], 1'b0, st_addr[i], st_data[i]);
            n_cmp++; if (mem_wd !== merged[i]) begin n_mis++; $display("FAIL sst_mem_wd[%0d]: got %h expected %h", i, mem_wd, merged[i]); end
            n_cmp++; if (mem_we !== 1'b1) begin n_mis++; $display("FAIL sst_mem_we[%0d]: got %b expected 1", i, mem_we); end
            @(posedge clk);
            #1;
            n_cmp++; if (resp_rdata !== 32'h0) begin n_mis++; $display("FAIL sst_rdata[%0d]: got %h expected 00000000", i, resp_rdata); end
            finish_resp();
            issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
            @(posedge clk);
            #1;
            n_cmp++; if (resp_rdata !== merged[i]) begin n_mis++; $display("FAIL sst_readback[%0d]: got %h expected %h", i, resp_rdata, merged[i]); end
            finish_resp();
        end
    endtask

    task automatic test_errors();
        logic        e_we   [4];
        logic [1:0]  e_size [4];
        logic [31:0] e_addr [4];
        int          wc;
        e_we   = '{1'b0, 1'b1, 1'b0, 1'b0};
        e_size = '{SZ_HALF, SZ_WORD, SZ_ILLEGAL, SZ_WORD};
        e_addr = '{32'h13, 32'h400, 32'h10, 32'h12};
        wc = we_count;
        for (int i = 0; i < 4; i++) begin
            issue(e_we[i], e_size[i], 1'b1, e_addr[i], 32'hCAFEF00D);
            n_cmp++; if (resp_valid !== 1'b1) begin n_mis++; $display("FAIL err_resp_valid[%0d]: got %b expected 1", i, resp_valid); end
            n_cmp++; if (resp_err !== 1'b1) begin n_mis++; $display("FAIL err_flag[%0d]: got %b expected 1", i, resp_err); end
            n_cmp++; if (resp_rdata !== 32'h0) begin n_mis++; $display("FAIL err_rdata[%0d]: got %h expected 00000000", i, resp_rdata); end
            n_cmp++; if (mem_we !== 1'b0) begin n_mis++; $display("FAIL err_mem_we[%0d]: got %b expected 0", i, mem_we); end
            finish_resp();
        end
        n_cmp++; if (we_count !== wc) begin n_mis++; $display("FAIL err_no_writes: got %0d writes expected 0", we_count - wc); end
        n_cmp++; if (mem[4] !== 32'h7734AABB) begin n_mis++; $display("FAIL err_mem4: got %h expected 7734AABB", mem[4]); end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = SZ_WORD;
        req_signed = 1'b0;
        req_addr  = 32'h14;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (resp_valid !== 1'b1) begin n_mis++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, resp_valid); end
            n_cmp++; if (resp_rdata !== 32'h7734AABB) begin n_mis++; $display("FAIL bp_rdata[%0d]: got %h expected 7734AABB", i, resp_rdata); end
            n_cmp++; if (req_ready !== 1'b0) begin n_mis++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, req_ready); end
            @(posedge clk);
            #1;
        end
        n_cmp++; if (resp_rdata !== 32'h7734AABB) begin n_mis++; $display("FAIL bp_rdata_hold: got %h expected 7734AABB", resp_rdata); end
        finish_resp();
        n_cmp++; if (resp_valid !== 1'b0) begin n_mis++; $display("FAIL bp_valid_drop: got %b expected 0", resp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL bp_ready_after: got %b expected 1", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_cmp++; if (req_ready !== 1'b0) begin n_mis++; $display("FAIL bp_second_accept: got %b expected 0", req_ready); end
        n_cmp++; if (mem_a !== 32'd5) begin n_mis++; $display("FAIL bp_second_mem_a: got %h expected 00000005", mem_a); end
        @(posedge clk);
        #1;
        n_cmp++; if (resp_rdata !== 32'h0BADF00D) begin n_mis++; $display("FAIL bp_second_rdata: got %h expected 0BADF00D", resp_rdata); end
        finish_resp();
    endtask

    task automatic test_reset_mid_store();
        int wc;
        wc = we_count;
        issue(1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h55);
        n_cmp++; if (mem_we !== 1'b1) begin n_mis++; $display("FAIL rst_pre_we: got %b expected 1", mem_we); end
        n_cmp++; if (mem_wd !== 32'h7734AA55) begin n_mis++; $display("FAIL rst_pre_wd: got %h expected 7734AA55", mem_wd); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_mis++; $display("FAIL rst_we_drop: got %b expected 0", mem_we); end
        n_cmp++; if (mem_a !== 32'h0) begin n_mis++; $display("FAIL rst_mem_a: got %h expected 00000000", mem_a); end
        @(posedge clk);
        #1;
        n_cmp++; if (mem[4] !== 32'h7734AABB) begin n_mis++; $display("FAIL rst_mem4: got %h expected 7734AABB", mem[4]); end
        n_cmp++; if (we_count !== wc) begin n_mis++; $display("FAIL rst_no_write: got %0d writes expected 0", we_count - wc); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_mis++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_mis++; $display("FAIL rst_resp_rdata: got %h expected 00000000", resp_rdata); end
        @(posedge clk);
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_mis++; $display("FAIL rst_stays_idle: got %b expected 0", resp_valid); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_word_store();
        test_loads();
        test_subword_store();
        test_errors();
        test_back_to_back();
        test_reset_mid_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
